// File: rtl/audio_pkg.sv
// audio_pkg: types and constants shared by the I2S receive and transmit paths
package audio_pkg;
  localparam int I2S_DEFAULT_WIDTH = 16;
  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} i2s_rx_state_t;
  typedef struct packed {
    logic [I2S_DEFAULT_WIDTH-1:0] left;
    logic [I2S_DEFAULT_WIDTH-1:0] right;
  } audio_frame_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: N-stage synchroniser with registered rise/fall strobes
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] s;
  logic p;
  // q is the sample the strobes were computed from, so data taken from q lines up with rise
  assign q = p;
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      p <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s <= {s[STAGES-2:0], d};
      p <= s[STAGES-1];
      rise <= s[STAGES-1] & ~p;
      fall <= ~s[STAGES-1] & p;
    end
  end
endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver delivering stereo frames on a valid/ready interface
module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  hclkin,
  input  logic                  reset,
  input  logic                  bclk_i,
  input  logic                  lrck_i,
  input  logic                  sdata_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o,
  output logic                  locked_o
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MSB = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic bclk_rise, lrck, sdata, lrck_prev, load;
  logic [1:0] unused_rise;
  logic [2:0] unused_fall;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] sr, word, left_hold, right_hold;
  i2s_rx_state_t state;
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_bclk (
    .clk(hclkin), .rst(reset), .d(bclk_i), .q(), .rise(bclk_rise), .fall(unused_fall[0])
  );
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_lrck (
    .clk(hclkin), .rst(reset), .d(lrck_i), .q(lrck), .rise(unused_rise[0]), .fall(unused_fall[1])
  );
  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sdata (
    .clk(hclkin), .rst(reset), .d(sdata_i), .q(sdata), .rise(unused_rise[1]), .fall(unused_fall[2])
  );
  // Bits land left-justified; once the counter saturates further bits are dropped
  always_comb word = sr | ((cnt != FULL && sdata) ? (MSB >> cnt) : '0);
  always_ff @(posedge hclkin) begin
    if (reset) begin
      state <= HUNT;
      cnt <= '0;
      sr <= '0;
      lrck_prev <= 1'b0;
      left_hold <= '0;
      right_hold <= '0;
      load <= 1'b0;
      left_o <= '0;
      right_o <= '0;
      valid_o <= 1'b0;
      overrun_o <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      load <= 1'b0;
      if (bclk_rise) begin
        lrck_prev <= lrck;
        sr <= word;
        cnt <= (cnt == FULL) ? cnt : cnt + 1'b1;
        // The bit on the LRCK-change edge is still the LSB of the word being closed
        if (lrck != lrck_prev) begin
          sr <= '0;
          cnt <= '0;
          if (state == HUNT && !lrck) state <= LEFT;
          else if (state == LEFT) begin
            left_hold <= word;
            state <= RIGHT;
          end else if (state == RIGHT) begin
            right_hold <= word;
            load <= 1'b1;
            state <= LEFT;
          end
        end
      end
      if (load) begin
        left_o <= left_hold;
        right_o <= right_hold;
        valid_o <= 1'b1;
        locked_o <= 1'b1;
        overrun_o <= valid_o && !ready_i;
      end else begin
        overrun_o <= 1'b0;
        if (ready_i) valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stream against a frame-level reference model
module tb_i2s_rx;
  localparam int DW = 16;
  localparam int NS = 2;
  logic hclkin = 1'b0, reset = 1'b1, bclk_i = 1'b0, lrck_i = 1'b1, sdata_i = 1'b0, ready_i = 1'b1;
  logic [DW-1:0] left_o, right_o;
  logic valid_o, overrun_o, locked_o;
  i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(NS)) dut (
    .hclkin(hclkin), .reset(reset), .bclk_i(bclk_i), .lrck_i(lrck_i), .sdata_i(sdata_i),
    .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .ready_i(ready_i),
    .overrun_o(overrun_o), .locked_o(locked_o)
  );
  always #5 hclkin = ~hclkin;

  typedef struct {int at; logic [DW-1:0] l; logic [DW-1:0] r;} ld_t;
  ld_t pending[$];
  int cyc = 0, checks = 0, errors = 0, last_at = 0, rmode = 1;
  bit aligned = 0;
  logic mv = 0, mo = 0, mlock = 0;
  logic [DW-1:0] ml = '0, mr = '0;

  function automatic logic [DW-1:0] expw(input logic [31:0] v, input int w);
    return w >= DW ? DW'(v >> (w - DW)) : DW'(v << (DW - w));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference: frames appear NS+2 cycles after the first sampling edge of their closing bclk rise
  always @(posedge hclkin) begin
    cyc++;
    if (reset) begin
      mv = 0; mo = 0; mlock = 0; ml = '0; mr = '0;
      pending.delete();
    end else if (pending.size() > 0 && pending[0].at == cyc) begin
      mo = mv && !ready_i;
      mv = 1; mlock = 1;
      ml = pending[0].l; mr = pending[0].r;
      void'(pending.pop_front());
    end else begin
      mo = 0;
      if (ready_i) mv = 0;
    end
  end

  always @(negedge hclkin) if (cyc > 0) begin
    chk("valid", 32'(valid_o), 32'(mv));
    chk("overrun", 32'(overrun_o), 32'(mo));
    chk("locked", 32'(locked_o), 32'(mlock));
    chk("left", 32'(left_o), 32'(ml));
    chk("right", 32'(right_o), 32'(mr));
  end

  always @(posedge hclkin) begin
    #1;
    ready_i = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 :
              rmode == 2 ? ($urandom_range(0, 2) != 0) : (cyc + 1 == last_at);
  end

  task automatic tick();
    @(posedge hclkin);
    #1;
  endtask

  task automatic send_bit(input logic lr, input logic d, input bit rst_here, input bit push,
                          input logic [DW-1:0] el, input logic [DW-1:0] er);
    ld_t e;
    bclk_i = 1'b0; lrck_i = lr; sdata_i = d;
    tick();
    if (rst_here) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    repeat ($urandom_range(1, 4)) tick();
    bclk_i = 1'b1;
    if (push) begin
      e.at = cyc + 1 + NS + 2; e.l = el; e.r = er;
      pending.push_back(e);
      last_at = e.at;
    end
    repeat ($urandom_range(2, 4)) tick();
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w, input int rst_bit);
    bit fa;
    logic [31:0] v;
    logic lr;
    fa = aligned;
    for (int j = 0; j < 2 * w; j++) begin
      v = j < w ? l : r;
      lr = (j == w - 1) ? 1'b1 : (j == 2 * w - 1) ? 1'b0 : (j >= w);
      if (j == rst_bit) begin fa = 0; aligned = 0; end
      send_bit(lr, v[w - 1 - (j % w)], j == rst_bit, fa && j == 2 * w - 1, expw(l, w), expw(r, w));
    end
    aligned = 1;
  endtask

  task automatic rnd_frame(input int w, input int rst_bit);
    logic [31:0] m;
    m = (32'h1 << w) - 1;
    send_frame($urandom & m, $urandom & m, w, rst_bit);
  endtask

  initial begin
    int ws[4] = '{12, 16, 20, 24};
    repeat (5) tick();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(i != 6, 1'($urandom), 0, 0, '0, '0);
    aligned = 1;
    send_frame(32'h0001, 32'h8000, 16, -1);
    send_frame(32'hA5C3, 32'h1234, 16, -1);
    send_frame(32'hABCDEF, $urandom & 32'hFFFFFF, 24, -1);
    send_frame(32'hFFF, $urandom & 32'hFFF, 12, -1);
    repeat (10) tick();
    rmode = 0;
    send_frame(32'h1111, 32'h2222, 16, -1);
    send_frame(32'h3333, 32'h4444, 16, -1);
    repeat (10) tick();
    rmode = 1;
    repeat (10) tick();
    rmode = 0;
    send_frame(32'h5555, 32'h6666, 16, -1);
    rmode = 3;
    send_frame(32'h7777, 32'h8888, 16, -1);
    repeat (10) tick();
    rmode = 1;
    repeat (5) tick();
    rnd_frame(16, 5);
    send_frame(32'hC0DE, 32'hBEEF, 16, -1);
    repeat (10) tick();
    rmode = 2;
    for (int i = 0; i < 14; i++) rnd_frame(ws[$urandom_range(0, 3)], ($urandom_range(0, 4) == 0) ? 3 : -1);
    bclk_i = 1'b0;
    rmode = 1;
    repeat (20) tick();
    chk("drained", 32'(pending.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
